// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the token-driven vending controller.
package vending_machine_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } state_t;

  localparam state_t RESET_STATE    = S01;
  localparam state_t DISPENSE_STATE = S11;
  localparam state_t PENDING_STATE  = S10;

endpackage

// File: rtl/vm_sat_counter.sv
// Generic W-bit saturating up-counter with enable and synchronous active-high reset.
module vm_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Once the counter reaches all-ones it stays there; it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vending_machine.sv
// Token-driven Moore vending controller with a saturating dispense counter.
// Optional macro VM_STATE_OUT_EN exposes the state register and a hold flag.
module vending_machine
  import vending_machine_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             T,
  output logic             A,
  output logic             P,
  output logic [CNT_W-1:0] disp_cnt
`ifdef VM_STATE_OUT_EN
  ,
  output logic [1:0]       state_o,
  output logic [0:0]       hold_o
`endif
);

  state_t state;
  state_t next_state;
  logic   enter_dispense;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = RESET_STATE;
    case (state)
      S01:     next_state = T ? S10 : S00;
      S00:     next_state = T ? S01 : S10;
      S10:     next_state = T ? S11 : S01;
      S11:     next_state = T ? S11 : S01;
      default: next_state = RESET_STATE;
    endcase
  end

  always_comb begin
    A = (state == DISPENSE_STATE);
    P = (state == PENDING_STATE);
  end

  // Count only arrivals into S11, not cycles spent holding there.
  assign enter_dispense = (next_state == DISPENSE_STATE) && (state != DISPENSE_STATE);

  vm_sat_counter #(
    .W(CNT_W)
  ) u_disp_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (enter_dispense),
    .count(disp_cnt)
  );

`ifdef VM_STATE_OUT_EN
  assign state_o = state;
  assign hold_o  = (state == DISPENSE_STATE) && T;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: directed token vectors with hand-computed
// expected states and counts; CNT_W=2 so saturation is reachable quickly.
module tb_vending_machine;
  import vending_machine_pkg::*;

  localparam int CNT_W = 2;

  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             hold;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             T;
  logic             A;
  logic             P;
  logic [CNT_W-1:0] disp_cnt;
`ifdef VM_STATE_OUT_EN
  logic [1:0]       state_o;
  logic [0:0]       hold_o;
`endif

  exp_t exp_q[$];
  int   assertions = 0;
  int   failures   = 0;

  always #5 clk = ~clk;

  vending_machine #(
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .T       (T),
    .A       (A),
    .P       (P),
    .disp_cnt(disp_cnt)
`ifdef VM_STATE_OUT_EN
    ,
    .state_o (state_o),
    .hold_o  (hold_o)
`endif
  );

  // Drive one edge's worth of input at the falling edge and queue what the
  // DUT must show after the following rising edge. A glitch pulses rst
  // between edges, which a synchronous reset must ignore.
  task automatic applyStimulus(input logic r, input logic t, input state_t st,
                               input logic [CNT_W-1:0] cnt, input bit glitch = 1'b0);
    exp_t e;
    @(negedge clk);
    T = t;
    e.st   = st;
    e.cnt  = cnt;
    e.hold = (st == S11) && t;
    exp_q.push_back(e);
    if (glitch) begin
      rst = 1'b1;
      #2;
      rst = 1'b0;
    end else begin
      rst = r;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    assertions++;
    if (A !== (e.st == S11)) begin
      failures++;
      $display("[TB] FAIL A: got %b expected %b (state %s)", A, (e.st == S11), e.st.name());
    end
    assertions++;
    if (P !== (e.st == S10)) begin
      failures++;
      $display("[TB] FAIL P: got %b expected %b (state %s)", P, (e.st == S10), e.st.name());
    end
    assertions++;
    if (disp_cnt !== e.cnt) begin
      failures++;
      $display("[TB] FAIL disp_cnt: got %0d expected %0d", disp_cnt, e.cnt);
    end
`ifdef VM_STATE_OUT_EN
    assertions++;
    if (state_o !== e.st) begin
      failures++;
      $display("[TB] FAIL state_o: got %b expected %b", state_o, e.st);
    end
    assertions++;
    if (hold_o !== e.hold) begin
      failures++;
      $display("[TB] FAIL hold_o: got %b expected %b", hold_o, e.hold);
    end
`endif
  endtask

  // Monitor: every rising edge is an output event; compare just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        checkOutput(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [CNT_W-1:0] sat_cnt [5];
    int guard;
    sat_cnt[0] = 2'd1; sat_cnt[1] = 2'd2; sat_cnt[2] = 2'd3;
    sat_cnt[3] = 2'd3; sat_cnt[4] = 2'd3;

    rst = 1'b1;
    T   = 1'b0;

    // Reset held two edges with T toggling
    applyStimulus(1'b1, 1'b1, S01, 2'd0);
    applyStimulus(1'b1, 1'b0, S01, 2'd0);

    // Full path 0,0,1,1,0,0,1,1,0
    applyStimulus(1'b0, 1'b0, S00, 2'd0);
    applyStimulus(1'b0, 1'b0, S10, 2'd0);
    applyStimulus(1'b0, 1'b1, S11, 2'd1);
    applyStimulus(1'b0, 1'b1, S11, 2'd1);
    applyStimulus(1'b0, 1'b0, S01, 2'd1);
    applyStimulus(1'b0, 1'b0, S00, 2'd1);
    applyStimulus(1'b0, 1'b1, S01, 2'd1);
    applyStimulus(1'b0, 1'b1, S10, 2'd1);
    applyStimulus(1'b0, 1'b0, S01, 2'd1);

    // Into S11, then hold for 10 edges
    applyStimulus(1'b0, 1'b1, S10, 2'd1);
    applyStimulus(1'b0, 1'b1, S11, 2'd2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, S11, 2'd2);
    end
    applyStimulus(1'b0, 1'b0, S01, 2'd2);

    // Saturation: reset, then five dispense cycles
    applyStimulus(1'b1, 1'b0, S01, 2'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, S10, (i == 0) ? 2'd0 : sat_cnt[i-1]);
      applyStimulus(1'b0, 1'b1, S11, sat_cnt[i]);
      applyStimulus(1'b0, 1'b0, S01, sat_cnt[i]);
    end

    // Mid-run reset from S10 with T=1
    applyStimulus(1'b0, 1'b1, S10, 2'd3);
    applyStimulus(1'b1, 1'b1, S01, 2'd0);

    // Reset pulse between edges is ignored
    applyStimulus(1'b0, 1'b1, S10, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, S11, 2'd1);
    applyStimulus(1'b0, 1'b0, S01, 2'd1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
Name: vending_machine

Overview:
- Small token-driven vending controller: 2-bit Moore FSM advanced on every rising clk edge by a single-bit token input T.
- Drives two status outputs: A (accept/dispense) and P (pending/partial).
- Also keeps a saturating count of dispense events for system-level monitoring.
- Leaf block; sits between the coin/token front end and the dispense actuator logic.

Parameters:
- CNT_W, 8, width of the dispense event counter disp_cnt (minimum 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- T  input  1  token input, sampled every rising clk edge.
- A  output  1  dispense indication; Moore output decoded from state.
- P  output  1  pending indication; Moore output decoded from state.
- disp_cnt  output  CNT_W  saturating count of entries into state S11.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- State encoding (2 bits): S00=2'b00, S01=2'b01, S10=2'b10, S11=2'b11. Reset/initial state is S01.
- Reset is sampled only on the rising clk edge. When rst=1, state <= S01 and disp_cnt <= 0, regardless of T or the current state, including reset asserted mid-sequence.
- Transitions, written as state,T -> next:
  - S01,0->S00; S01,1->S10
  - S00,0->S10; S00,1->S01
  - S10,0->S01; S10,1->S11
  - S11,0->S01; S11,1->S11 (holds while T=1)
- Every state/input pair is defined, so no illegal states are reachable. The default branch of the next-state logic goes to S01.
- Outputs are purely combinational decodes of the state register; they change 0 cycles after the state edge and never depend on T directly:
  - A = (state==S11)
  - P = (state==S10)
  - Reset values: A=0, P=0.
- disp_cnt increments by 1 on each transition from a state other than S11 into S11. Staying in S11 (S11,T=1) does not increment.
- disp_cnt saturates at 2^CNT_W-1 and never wraps.
- There is no handshake; T is assumed synchronous to clk and is consumed every cycle.

Optional Feature:
- Macro VM_STATE_OUT_EN.
- When defined: adds output port state_o [1:0], which carries the current state register directly, and output port hold_o [0:0], which is 1 when state==S11 and T==1 (combinational).
- When not defined: these ports do not exist; all other behaviour is identical.

Decomposition:
- Shared package vending_machine_pkg holds:
  - the state enum/typedef (S00, S01, S10, S11) and RESET_STATE=S01;
  - the output decode constants.
- One natural sub-module, vm_sat_counter: a generic CNT_W-bit saturating incrementer with an enable, used for disp_cnt. The FSM itself stays in the top module.

Test Plan:
- Reset: hold rst=1 for 2 edges with T toggling -> state S01, A=0, P=0, disp_cnt=0. Reset is not honoured between edges (synchronous).
- Full path: after reset, apply T per edge as 0,0,1,1,0,0,1,1,0.
  - Required states: S00,S10,S11,S11,S01,S00,S01,S10,S01.
  - A high only for the two S11 cycles; P high only in S10 cycles.
  - disp_cnt=1 at end.
- Hold: from S11 apply T=1 for 10 edges -> state stays S11, A stays 1, disp_cnt unchanged.
- Saturation with CNT_W=2: repeat the cycle S01 -T=1-> S10 -T=1-> S11 -T=0-> S01 five times -> disp_cnt reads 1,2,3,3,3.
- Mid-run reset: in S10, assert rst=1 with T=1 for one edge -> next state S01 (not S11), P drops, disp_cnt=0.
- VM_STATE_OUT_EN build: state_o tracks the encoding above every cycle; hold_o=1 only when in S11 with T=1.
